rf_nr1w: RTL and testbench
==========================

RF_NR1W -- requirements
Module: rf_nr1w

Interface
REQ-001 SHALL provide parameter DW, default 32, data width in bits.
REQ-002 SHALL provide parameter AW, default 5, address width; DEPTH = 2**AW entries.
REQ-003 SHALL provide parameter NRD, default 2, number of independent read ports (1..4).
REQ-004 SHALL provide parameter ZERO_R0, default 1; when 1, entry 0 reads as zero and ignores writes.
REQ-005 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port ram_ren, input, NRD, per-port read enable; bit p belongs to port p.
REQ-008 SHALL have port ram_radr, input, NRD*AW, packed read addresses; port p at bits [p*AW +: AW].
REQ-009 SHALL have port ram_rdata, output, NRD*DW, packed registered read data; port p at [p*DW +: DW].
REQ-010 SHALL have port ram_wadr, input, AW, write address.
REQ-011 SHALL have port ram_wdata, input, DW, write data.
REQ-012 SHALL have port ram_wen, input, 1, write enable.
REQ-013 SHALL have port rf_ready, output, 1, high once the post-reset clear sweep is complete.

Function
REQ-014 SHALL implement a two-state FSM: CLEAR, then READY; READY is terminal until reset.
REQ-015 SHALL, in CLEAR, write zero to entry clr_cnt each cycle, with clr_cnt counting 0..DEPTH-1, then move to READY on the edge that clears entry DEPTH-1.
REQ-016 SHALL hold rf_ready=0 in CLEAR and 1 in READY; rf_ready rises exactly DEPTH rising edges after rst_n deasserts.
REQ-017 SHALL ignore ram_wen in CLEAR; no user write reaches the array.
REQ-018 SHALL load ram_rdata port p with zero in CLEAR when ram_ren[p]=1.
REQ-019 SHALL, in READY with ram_wen=1, write ram_wdata to ram_wadr on the rising edge, except when ZERO_R0=1 and ram_wadr=0.
REQ-020 SHALL, in READY with ram_ren[p]=1, load port p's output register at the rising edge with the entry at its address; data is visible the cycle after the address is presented (latency 1).
REQ-021 SHALL hold port p's output unchanged when ram_ren[p]=0, including across writes to the address last read.
REQ-022 SHALL bypass write-first: if ram_wen=1 and ram_wadr equals port p's address in the same cycle, port p loads ram_wdata, not the old entry.
REQ-023 SHALL return zero on any port reading address 0 when ZERO_R0=1, regardless of bypass.
REQ-024 SHALL let all NRD ports read the same or different addresses in the same cycle without interference.
REQ-025 SHALL use only the low AW bits of each address; no out-of-range case exists.

Reset
REQ-026 SHALL, while rst_n=0, force all ram_rdata to zero, rf_ready=0, the FSM to CLEAR and clr_cnt to 0, asynchronously.
REQ-027 SHALL restart the full clear sweep from entry 0 if rst_n is asserted mid-sweep or in READY.
REQ-028 SHALL not require the storage array itself to have a reset; zeroing comes only from the sweep.

Verification
REQ-029 SHALL cover the clear sweep: release rst_n with AW=5, then read all 32 entries -> rf_ready rises on edge 32; every entry reads 0x00000000.
REQ-030 SHALL cover write then read: write 0xDEADBEEF to addr 7; the next cycle, port 0 reads addr 7 -> ram_rdata[31:0]=0xDEADBEEF one cycle later.
REQ-031 SHALL cover same-cycle bypass: addr 9 holds 0x11111111; write 0x22222222 to addr 9 while port 1 reads addr 9 -> port 1 shows 0x22222222.
REQ-032 SHALL cover the zero register: with ZERO_R0=1, write 0xFFFFFFFF to addr 0 while both ports read addr 0 -> both ports return 0 then and in every later read.
REQ-033 SHALL cover hold: port 0 reads addr 3=0xA5A5A5A5, then ram_ren[0]=0 while 0x5A5A5A5A is written to addr 3 -> port 0 keeps 0xA5A5A5A5.
REQ-034 SHALL cover reset mid-sweep: assert rst_n at sweep cycle 10 and release -> outputs are 0 immediately; rf_ready rises 32 edges after release; writes before then are ignored.

Source files
------------

// File: rtl/rf_nr1w.sv
// Register file with NRD registered read ports and one write port.
// After reset, a sweep zeroes every entry before rf_ready rises.
module rf_nr1w #(
    parameter int DW      = 32,
    parameter int AW      = 5,
    parameter int NRD     = 2,
    parameter int ZERO_R0 = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NRD-1:0]    ram_ren,
    input  logic [NRD*AW-1:0] ram_radr,
    output logic [NRD*DW-1:0] ram_rdata,
    input  logic [AW-1:0]     ram_wadr,
    input  logic [DW-1:0]     ram_wdata,
    input  logic              ram_wen,
    output logic              rf_ready
);

    localparam int DEPTH = 2**AW;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [0:0]    state_reg, state_next;
    logic [AW-1:0] clr_cnt_reg, clr_cnt_next;

    logic [DW-1:0] mem [DEPTH];
    logic          mem_we;
    logic [AW-1:0] mem_wadr;
    logic [DW-1:0] mem_wdata;
    logic          user_wen;

    // Entry 0 is hardwired to zero when ZERO_R0 is set, so its writes are dropped.
    assign user_wen = ram_wen && !((ZERO_R0 != 0) && (ram_wadr == '0));

    always_comb begin
        state_next   = state_reg;
        clr_cnt_next = clr_cnt_reg;
        mem_we       = 1'b0;
        mem_wadr     = ram_wadr;
        mem_wdata    = ram_wdata;
        case (state_reg)
            ST_CLEAR: begin
                mem_we       = 1'b1;
                mem_wadr     = clr_cnt_reg;
                mem_wdata    = '0;
                clr_cnt_next = clr_cnt_reg + 1'b1;
                if (clr_cnt_reg == '1) begin
                    state_next = ST_READY;
                end
            end
            default: begin
                mem_we = user_wen;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_CLEAR;
            clr_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clr_cnt_reg <= clr_cnt_next;
        end
    end

    // Storage has no reset; the sweep is the only thing that zeroes it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wadr] <= mem_wdata;
        end
    end

    assign rf_ready = (state_reg == ST_READY);

    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
        logic [AW-1:0] radr;
        logic [DW-1:0] rd_next;
        logic [DW-1:0] rd_reg;

        assign radr = ram_radr[gi*AW +: AW];

        // Write-first bypass, but the zero register wins over it.
        always_comb begin
            if (state_reg != ST_READY) begin
                rd_next = '0;
            end else if ((ZERO_R0 != 0) && (radr == '0)) begin
                rd_next = '0;
            end else if (ram_wen && (ram_wadr == radr)) begin
                rd_next = ram_wdata;
            end else begin
                rd_next = mem[radr];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_reg <= '0;
            end else if (ram_ren[gi]) begin
                rd_reg <= rd_next;
            end
        end

        assign ram_rdata[gi*DW +: DW] = rd_reg;
    end

endmodule

// File: tb/tb_rf_nr1w.sv
// Directed bench for rf_nr1w: reference model checked every cycle,
// plus literal expectations at the interesting transactions.
module tb_rf_nr1w;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NRD   = 2;
    localparam int DEPTH = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NRD-1:0]    ram_ren;
    logic [NRD*AW-1:0] ram_radr;
    logic [NRD*DW-1:0] ram_rdata;
    logic [AW-1:0]     ram_wadr;
    logic [DW-1:0]     ram_wdata;
    logic              ram_wen;
    logic              rf_ready;

    int vectors     = 0;
    int miscompares = 0;
    bit cmp_en      = 1'b0;

    rf_nr1w #(.DW(DW), .AW(AW), .NRD(NRD), .ZERO_R0(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ram_ren   (ram_ren),
        .ram_radr  (ram_radr),
        .ram_rdata (ram_rdata),
        .ram_wadr  (ram_wadr),
        .ram_wdata (ram_wdata),
        .ram_wen   (ram_wen),
        .rf_ready  (rf_ready)
    );

    always #5 clk = ~clk;

    // Reference model: ready after DEPTH edges, contents zero at that point,
    // reads during the sweep return zero, entry 0 always reads zero.
    logic [DW-1:0] mem_m [DEPTH];
    logic [DW-1:0] exp_rd [NRD];
    int            edges;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edges = 0;
            for (int p = 0; p < NRD; p++) exp_rd[p] = '0;
        end else begin
            bit was_ready;
            was_ready = (edges >= DEPTH);
            for (int p = 0; p < NRD; p++) begin
                logic [AW-1:0] a;
                a = ram_radr[p*AW +: AW];
                if (ram_ren[p]) begin
                    if (!was_ready || a == 0)              exp_rd[p] = '0;
                    else if (ram_wen && ram_wadr == a)     exp_rd[p] = ram_wdata;
                    else                                   exp_rd[p] = mem_m[a];
                end
            end
            if (was_ready && ram_wen && ram_wadr != 0) mem_m[ram_wadr] = ram_wdata;
            if (!was_ready) begin
                edges = edges + 1;
                if (edges == DEPTH) begin
                    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_p0", ram_rdata[31:0], exp_rd[0]);
            chk("model_p1", ram_rdata[63:32], exp_rd[1]);
            chk("model_ready", {31'd0, rf_ready}, {31'd0, (edges >= DEPTH)});
        end
    end

    task automatic apply(input logic [1:0] ren, input logic [4:0] a0, input logic [4:0] a1,
                         input logic wen, input logic [4:0] wa, input logic [31:0] wd);
        ram_ren   = ren;
        ram_radr  = {a1, a0};
        ram_wen   = wen;
        ram_wadr  = wa;
        ram_wdata = wd;
        @(posedge clk);
        #1;
        $display("txn ren=%b a0=%0d a1=%0d wen=%b wa=%0d wd=%h -> p0=%h p1=%h rdy=%b",
                 ren, a0, a1, wen, wa, wd, ram_rdata[31:0], ram_rdata[63:32], rf_ready);
    endtask

    task automatic wait_ready(input string name);
        int k;
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            apply(2'b11, 5'd5, 5'd7, 1'b1, 5'd5, 32'h12345678);
            if (rf_ready) begin
                k = i;
                break;
            end
        end
        chk(name, k, 32);
    endtask

    initial begin
        rst_n     = 1'b0;
        ram_ren   = '0;
        ram_radr  = '0;
        ram_wen   = 1'b0;
        ram_wadr  = '0;
        ram_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        cmp_en = 1'b1;
        chk("rst_p0", ram_rdata[31:0], 32'h0);
        chk("rst_p1", ram_rdata[63:32], 32'h0);
        chk("rst_ready", {31'd0, rf_ready}, 32'd0);

        rst_n = 1'b1;
        wait_ready("ready_edge");

        for (int i = 0; i < DEPTH; i++) begin
            apply(2'b11, 5'(i), 5'(31 - i), 1'b0, 5'd0, 32'h0);
            chk("sweep_p0", ram_rdata[31:0], 32'h0);
            chk("sweep_p1", ram_rdata[63:32], 32'h0);
        end

        apply(2'b00, 5'd0, 5'd0, 1'b1, 5'd7, 32'hDEADBEEF);
        apply(2'b01, 5'd7, 5'd0, 1'b0, 5'd0, 32'h0);
        chk("wr_rd_7", ram_rdata[31:0], 32'hDEADBEEF);

        apply(2'b00, 5'd0, 5'd0, 1'b1, 5'd9, 32'h11111111);
        apply(2'b10, 5'd0, 5'd9, 1'b1, 5'd9, 32'h22222222);
        chk("bypass_p1", ram_rdata[63:32], 32'h22222222);
        chk("bypass_p0_hold", ram_rdata[31:0], 32'hDEADBEEF);
        apply(2'b01, 5'd9, 5'd0, 1'b0, 5'd0, 32'h0);
        chk("after_bypass_p0", ram_rdata[31:0], 32'h22222222);

        apply(2'b11, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF);
        chk("r0_wr_p0", ram_rdata[31:0], 32'h0);
        chk("r0_wr_p1", ram_rdata[63:32], 32'h0);
        apply(2'b11, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0);
        chk("r0_later_p0", ram_rdata[31:0], 32'h0);
        chk("r0_later_p1", ram_rdata[63:32], 32'h0);

        apply(2'b00, 5'd0, 5'd0, 1'b1, 5'd3, 32'hA5A5A5A5);
        apply(2'b01, 5'd3, 5'd0, 1'b0, 5'd0, 32'h0);
        chk("hold_load", ram_rdata[31:0], 32'hA5A5A5A5);
        apply(2'b00, 5'd3, 5'd0, 1'b1, 5'd3, 32'h5A5A5A5A);
        apply(2'b00, 5'd3, 5'd0, 1'b0, 5'd0, 32'h0);
        chk("hold_keep", ram_rdata[31:0], 32'hA5A5A5A5);
        apply(2'b01, 5'd3, 5'd0, 1'b0, 5'd0, 32'h0);
        chk("hold_reread", ram_rdata[31:0], 32'h5A5A5A5A);

        apply(2'b11, 5'd7, 5'd3, 1'b0, 5'd0, 32'h0);
        chk("multi_p0", ram_rdata[31:0], 32'hDEADBEEF);
        chk("multi_p1", ram_rdata[63:32], 32'h5A5A5A5A);
        apply(2'b11, 5'd9, 5'd9, 1'b1, 5'd10, 32'hCAFEF00D);
        chk("same_p0", ram_rdata[31:0], 32'h22222222);
        chk("same_p1", ram_rdata[63:32], 32'h22222222);

        // Reset while READY: outputs clear without waiting for a clock edge.
        rst_n = 1'b0;
        #1;
        chk("async_rst_p0", ram_rdata[31:0], 32'h0);
        chk("async_rst_ready", {31'd0, rf_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) apply(2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0);
        apply(2'b11, 5'd7, 5'd9, 1'b1, 5'd7, 32'h77777777);

        // Abort the sweep partway through and restart it.
        rst_n = 1'b0;
        #1;
        chk("mid_rst_p0", ram_rdata[31:0], 32'h0);
        chk("mid_rst_ready", {31'd0, rf_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_ready("ready_edge_restart");

        apply(2'b11, 5'd7, 5'd9, 1'b0, 5'd0, 32'h0);
        chk("cleared_7", ram_rdata[31:0], 32'h0);
        chk("cleared_9", ram_rdata[63:32], 32'h0);
        apply(2'b11, 5'd5, 5'd10, 1'b0, 5'd0, 32'h0);
        chk("ignored_wr_5", ram_rdata[31:0], 32'h0);
        chk("cleared_10", ram_rdata[63:32], 32'h0);
        apply(2'b00, 5'd0, 5'd0, 1'b1, 5'd31, 32'h31313131);
        apply(2'b10, 5'd0, 5'd31, 1'b0, 5'd0, 32'h0);
        chk("top_entry", ram_rdata[63:32], 32'h31313131);

        apply(2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0);
        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
